// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//
// Program-counter unit for the IF stage of the pipelined MIPS core. It holds
// the fetch PC and selects the next PC each cycle. Sources, highest priority
// first:
//   exception entry (req), eret / branch-jump redirect, stall hold,
//   release of a buffered redirect, sequential increment.
//
// A redirect that arrives while the pipeline is stalled is parked in a
// one-entry buffer (state PEND). It is applied on the first unstalled edge,
// so a taken branch seen during a hazard is never lost.
//
// Optional feature, selected by the macro FETCH_PC_ADEL_CHECK_EN:
//   defined   - exc_adel flags a misaligned PC or a PC outside
//               [IMEM_BASE, IMEM_BASE+IMEM_SIZE).
//   undefined - exc_adel is tied low and no compare logic is built.
//
// Ports:
//   clk              in   clock
//   reset            in   synchronous, active-high reset
//   stall            in   hold the PC this cycle (hazard unit)
//   req              in   exception/interrupt taken -> HANDLER_VEC
//   eret             in   return from exception -> epc
//   epc              in   return target for eret
//   redirect_valid   in   branch/jump taken
//   redirect_target  in   branch/jump target
//   pc               out  current fetch PC (registered)
//   pc_plus4         out  pc + 4 (combinational, wraps)
//   pending          out  pending-redirect buffer occupied
//   exc_adel         out  fetch address error on the current pc
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VEC   = 32'h0000_3000,
    parameter logic [WIDTH-1:0] HANDLER_VEC = 32'h0000_4180,
    parameter logic [WIDTH-1:0] IMEM_BASE   = 32'h0000_3000,
    parameter logic [WIDTH-1:0] IMEM_SIZE   = 32'h0000_4000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             req,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             pending,
    output logic             exc_adel
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t           state_reg,       state_next;
    logic [WIDTH-1:0] pc_reg,          pc_next;
    logic [WIDTH-1:0] pend_target_reg, pend_target_next;

    logic             redirect_any;
    logic [WIDTH-1:0] redirect_eff;
    logic [WIDTH-1:0] pc_inc;

    // eret wins over a simultaneous branch/jump redirect.
    assign redirect_any = eret | redirect_valid;
    assign redirect_eff = eret ? epc : redirect_target;

    // Plain WIDTH-bit add: wraps modulo 2^WIDTH.
    assign pc_inc = pc_reg + WIDTH'(4);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            pc_reg          <= RESET_VEC;
            pend_target_reg <= '0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            pend_target_reg <= pend_target_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-PC / next-state selection
    // -------------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        pend_target_next = pend_target_reg;

        if (req) begin
            // Exception entry overrides a stall and drops any parked target.
            pc_next    = HANDLER_VEC;
            state_next = ST_IDLE;
        end else if (redirect_any) begin
            if (stall) begin
                // Park the redirect; a newer one simply overwrites the older.
                pend_target_next = redirect_eff;
                state_next       = ST_PEND;
            end else begin
                // A fresh redirect supersedes whatever was parked.
                pc_next    = redirect_eff;
                state_next = ST_IDLE;
            end
        end else if (stall) begin
            // Hold everything, including a parked target.
            pc_next = pc_reg;
        end else begin
            case (state_reg)
                ST_PEND: begin
                    pc_next    = pend_target_reg;
                    state_next = ST_IDLE;
                end
                default: begin
                    pc_next = pc_inc;
                end
            endcase
        end
    end

    assign pc       = pc_reg;
    assign pc_plus4 = pc_inc;
    assign pending  = (state_reg == ST_PEND);

    // -------------------------------------------------------------------------
    // Fetch address-error check
    // -------------------------------------------------------------------------
`ifdef FETCH_PC_ADEL_CHECK_EN
    // Bounds are formed one bit wider than the PC so IMEM_BASE + IMEM_SIZE
    // cannot wrap and silently shrink the legal window.
    logic [WIDTH:0] pc_wide;
    logic [WIDTH:0] base_wide;
    logic [WIDTH:0] limit_wide;
    logic           misaligned;
    logic           below_base;
    logic           at_or_above_limit;

    assign pc_wide           = {1'b0, pc_reg};
    assign base_wide         = {1'b0, IMEM_BASE};
    assign limit_wide        = {1'b0, IMEM_BASE} + {1'b0, IMEM_SIZE};
    assign misaligned        = (pc_reg[1:0] != 2'b00);
    assign below_base        = (pc_wide < base_wide);
    assign at_or_above_limit = (pc_wide >= limit_wide);

    // Flag only; the PC keeps advancing and CP0 decides whether to raise req.
    assign exc_adel = misaligned | below_base | at_or_above_limit;
`else
    assign exc_adel = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_unit
//
// Scoreboard bench for fetch_pc_unit. The driver applies one cycle of inputs
// at a time, advances a behavioural reference model of the PC rules and
// pushes the expected post-edge outputs into a queue. An independent monitor
// pops one entry after every rising edge and compares it with the DUT. The
// buffered redirect is modelled as a queue of at most one target.
// -----------------------------------------------------------------------------
module tb_fetch_pc_unit;

    localparam logic [31:0] RESET_VEC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_VEC = 32'h0000_4180;
    localparam logic [31:0] IMEM_BASE   = 32'h0000_3000;
    localparam logic [31:0] IMEM_SIZE   = 32'h0000_4000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        req = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] epc = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pending;
    logic        exc_adel;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        pending;
        logic        adel;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state.
    logic [31:0] m_pc = '0;
    logic [31:0] m_park[$];

    fetch_pc_unit #(
        .WIDTH      (32),
        .RESET_VEC  (RESET_VEC),
        .HANDLER_VEC(HANDLER_VEC),
        .IMEM_BASE  (IMEM_BASE),
        .IMEM_SIZE  (IMEM_SIZE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .req            (req),
        .eret           (eret),
        .epc            (epc),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .pending        (pending),
        .exc_adel       (exc_adel)
    );

    always #5 clk = ~clk;

    function automatic logic model_adel(input logic [31:0] a);
`ifdef FETCH_PC_ADEL_CHECK_EN
        longint unsigned addr;
        longint unsigned lo;
        longint unsigned hi;
        addr = longint'(a);
        lo   = longint'(IMEM_BASE);
        hi   = lo + longint'(IMEM_SIZE);
        return (addr % 4 != 0) || (addr < lo) || (addr >= hi);
`else
        return (a === 32'hxxxx_xxxx); // never true for a known address
`endif
    endfunction

    // Apply one cycle of stimulus, update the model, queue the expectation.
    task automatic step(input logic rst, input logic st, input logic rq,
                        input logic er, input logic [31:0] ep,
                        input logic rv, input logic [31:0] rt);
        exp_t e;
        @(negedge clk);
        reset = rst; stall = st; req = rq; eret = er; epc = ep;
        redirect_valid = rv; redirect_target = rt;

        if (rst) begin
            m_pc = RESET_VEC;
            m_park.delete();
        end else if (rq) begin
            m_pc = HANDLER_VEC;
            m_park.delete();
        end else if (er || rv) begin
            m_park.delete();
            if (st) m_park.push_back(er ? ep : rt);
            else    m_pc = er ? ep : rt;
        end else if (!st) begin
            if (m_park.size() != 0) m_pc = m_park.pop_front();
            else                    m_pc = m_pc + 32'd4;
        end

        e.pc       = m_pc;
        e.pc_plus4 = m_pc + 32'd4;
        e.pending  = (m_park.size() != 0);
        e.adel     = model_adel(m_pc);
        exp_q.push_back(e);

        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0, '0);
    endtask

    task automatic redir(input logic st, input logic [31:0] t);
        step(0, st, 0, 0, '0, 1, t);
    endtask

    // Direct checks against fixed values from the test plan.
    task automatic expect_pc(input string name, input logic [31:0] want_pc,
                             input logic want_pend);
        total++;
        if (pc !== want_pc || pending !== want_pend) begin
            bad++;
            $display("FAIL %s: pc=%h pending=%b, required pc=%h pending=%b",
                     name, pc, pending, want_pc, want_pend);
        end
    endtask

    task automatic expect_adel(input string name, input logic want);
        total++;
        if (exc_adel !== want) begin
            bad++;
            $display("FAIL %s: exc_adel=%b, required %b", name, exc_adel, want);
        end
    endtask

    // Monitor: one scoreboard entry per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total += 4;
                if (pc !== e.pc) begin
                    bad++;
                    $display("FAIL sb_pc: got %h, required %h", pc, e.pc);
                end
                if (pc_plus4 !== e.pc_plus4) begin
                    bad++;
                    $display("FAIL sb_pc_plus4: got %h, required %h", pc_plus4, e.pc_plus4);
                end
                if (pending !== e.pending) begin
                    bad++;
                    $display("FAIL sb_pending: got %b, required %b", pending, e.pending);
                end
                if (exc_adel !== e.adel) begin
                    bad++;
                    $display("FAIL sb_exc_adel: got %b, required %b", exc_adel, e.adel);
                end
                $display("cycle pc=%h pc_plus4=%h pending=%b exc_adel=%b", pc, pc_plus4, pending, exc_adel);
            end
        end
    end

    // Watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    logic adel_exp_on;

    initial begin
        logic        r_rst, r_st, r_rq, r_er, r_rv;
        logic [31:0] r_ep, r_rt;

`ifdef FETCH_PC_ADEL_CHECK_EN
        adel_exp_on = 1'b1;
`else
        adel_exp_on = 1'b0;
`endif

        // Reset and free run.
        step(1, 0, 0, 0, '0, 0, '0);
        expect_pc("reset_pc", 32'h3000, 1'b0);
        expect_adel("reset_adel", 1'b0);
        total++;
        if (pc_plus4 !== 32'h3004) begin
            bad++;
            $display("FAIL reset_pc_plus4: got %h, required %h", pc_plus4, 32'h3004);
        end
        idle(1); expect_pc("seq_3004", 32'h3004, 1'b0);
        idle(1); expect_pc("seq_3008", 32'h3008, 1'b0);
        idle(1); expect_pc("seq_300c", 32'h300C, 1'b0);
        idle(1); expect_pc("seq_3010", 32'h3010, 1'b0);

        // Redirect arriving during a stall is parked then released.
        redir(1, 32'h3400);            expect_pc("park_hold0", 32'h3010, 1'b1);
        step(0, 1, 0, 0, '0, 0, '0);   expect_pc("park_hold1", 32'h3010, 1'b1);
        step(0, 1, 0, 0, '0, 0, '0);   expect_pc("park_hold2", 32'h3010, 1'b1);
        idle(1);                       expect_pc("park_release", 32'h3400, 1'b0);
        idle(1);                       expect_pc("park_after", 32'h3404, 1'b0);

        // req during stall with a parked target discards the target.
        redir(1, 32'h3600);            expect_pc("req_setup", 32'h3404, 1'b1);
        step(0, 1, 1, 0, '0, 0, '0);   expect_pc("req_in_stall", 32'h4180, 1'b0);
        idle(1);                       expect_pc("req_no_target", 32'h4184, 1'b0);

        // eret wins over a simultaneous branch.
        step(0, 0, 0, 1, 32'h3020, 1, 32'h3500);
        expect_pc("eret_priority", 32'h3020, 1'b0);

        // Address-error boundaries.
        redir(0, 32'h3002); expect_adel("adel_misaligned", adel_exp_on);
        redir(0, 32'h7000); expect_adel("adel_at_limit", adel_exp_on);
        redir(0, 32'h6FFC); expect_adel("adel_last_word", 1'b0);
        redir(0, 32'h2FFC); expect_adel("adel_below_base", adel_exp_on);

        // Wrap-around.
        redir(0, 32'hFFFF_FFFC); expect_pc("wrap_setup", 32'hFFFF_FFFC, 1'b0);
        idle(1);                 expect_pc("wrap_zero", 32'h0000_0000, 1'b0);

        // Reset while PEND drops the parked target.
        redir(1, 32'h3800);
        step(1, 1, 0, 0, '0, 0, '0); expect_pc("reset_in_pend", 32'h3000, 1'b0);
        idle(1);                     expect_pc("reset_drop", 32'h3004, 1'b0);

        // Randomised traffic, checked only through the scoreboard.
        for (int i = 0; i < 400; i++) begin
            r_rst = ($urandom_range(99) < 2);
            r_st  = ($urandom_range(99) < 45);
            r_rq  = ($urandom_range(99) < 5);
            r_er  = ($urandom_range(99) < 8);
            r_rv  = ($urandom_range(99) < 20);
            r_ep  = IMEM_BASE + ($urandom_range(32'h0FFF) << 2);
            if ($urandom_range(9) == 0) r_rt = $urandom();
            else                        r_rt = IMEM_BASE + ($urandom_range(32'h0FFF) << 2);
            step(r_rst, r_st, r_rq, r_er, r_ep, r_rv, r_rt);
        end

        idle(2);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d entries left, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
